ddram_burst_arbiter: RTL and testbench
======================================

DDRAM_BURST_ARBITER -- requirements
Module: ddram_burst_arbiter

Interface
REQ-001 Parameter: ADDR_W, 29, DDRAM word-address width.
REQ-002 Parameter: MAX_BURST, 128, largest burst length accepted; any larger request SHALL be clamped to this value.
REQ-003 Port: clk  in  1  DDRAM clock, the only clock; all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req0_rd / req1_rd  in  1 each  read request, held high until acked.
REQ-006 Port: req0_addr / req1_addr  in  ADDR_W each  burst start address.
REQ-007 Port: req0_burstcnt / req1_burstcnt  in  8 each  burst length in 64-bit beats.
REQ-008 Port: req0_ack / req1_ack  out  1 each  one-cycle pulse: command accepted by DDRAM.
REQ-009 Port: rd_data  out  64  registered read beat, shared by both requesters.
REQ-010 Port: req0_valid / req1_valid  out  1 each  rd_data belongs to this requester this cycle.
REQ-011 Port: halt  in  1  level, safe-stop request.
REQ-012 Port: halted  out  1  high while parked in HALTED.
REQ-013 Port: protocol_err  out  1  sticky: beat arrived with no burst outstanding.
REQ-014 Port: ddram_busy  in  1; ddram_dout  in  64; ddram_dout_ready  in  1  DDRAM response side.
REQ-015 Port: ddram_rd  out  1; ddram_addr  out  ADDR_W; ddram_burstcnt  out  8  DDRAM command side.

Function
REQ-016 States: IDLE, CMD, DATA, HALTED.
REQ-017 IDLE: halt=1 -> HALTED (priority over requests); else if any reqN_rd, grant one, latch its addr/burstcnt, -> CMD next cycle.
REQ-018 Grant: round-robin; the last-served requester loses ties; after reset, req0 wins ties.
REQ-019 Burstcnt 0 SHALL be issued as 1; values above MAX_BURST are clamped.
REQ-020 CMD: ddram_rd=1 with latched addr/burstcnt; held while ddram_busy=1; on cycle with ddram_busy=0: reqN_ack pulses same cycle, beat counter cleared, -> DATA; ddram_rd=0 from next cycle.
REQ-021 Request-to-ddram_rd latency: exactly 1 cycle from IDLE sampling reqN_rd=1.
REQ-022 ddram_addr and ddram_burstcnt SHALL stay constant from CMD entry until the final beat of that burst (burst-constant rule); they are never zeroed mid-burst.
REQ-023 DATA: each ddram_dout_ready=1 registers ddram_dout into rd_data and asserts the granted reqN_valid the following cycle (1-cycle latency); ddram_busy ignored for beats.
REQ-024 Beat counter 8-bit; beat with count = burstcnt-1 ends burst: -> HALTED if halt=1 that cycle, else IDLE; last-served updated.
REQ-025 halt asserted during CMD or DATA SHALL NOT abort the burst; all beats are delivered before HALTED.
REQ-026 HALTED: ddram_rd=0, no grants, halted=1; halt=0 -> IDLE next cycle.
REQ-027 ddram_dout_ready=1 in IDLE, CMD or HALTED: beat discarded, no valid, protocol_err set until reset.
REQ-028 A requester dropping reqN_rd after grant does not cancel the burst; its beats are still delivered.
REQ-029 Simultaneous ack and new request from the other requester: the new request waits until IDLE.

Reset
REQ-030 reset=1: state IDLE, ddram_rd=0, ddram_addr=0, ddram_burstcnt=0, reqN_ack=0, reqN_valid=0, rd_data=0, halted=0, protocol_err=0, counter=0, tie priority to req0.
REQ-031 Reset mid-burst SHALL take effect next edge; late beats then set protocol_err.

Structure
REQ-032 Package ddram_arb_pkg: state enum, ADDR_W and MAX_BURST defaults, burst-length clamp constant.
REQ-033 One sub-module, rr_arbiter2: two-input round-robin grant with last-served register; everything else flat.

Verification
REQ-034 req0 burst 4 @0x2400000, busy=0 -> ddram_rd high 1 cycle, burstcnt=4, ack0 pulse, 4 valid0 beats, back to IDLE.
REQ-035 Both requesting continuously, burst 2 each -> grants alternate 0,1,0,1; no beat misrouted.
REQ-036 busy=1 for 5 cycles in CMD -> ddram_rd and addr held stable 5 cycles, ack on 6th.
REQ-037 halt raised at beat 3 of burst 128 -> all 128 beats delivered, then halted=1, no new ddram_rd; halt=0 -> IDLE.
REQ-038 burstcnt 0 and 200 -> issued as 1 and 128.
REQ-039 Reset at beat 10 of 128, then beats continue -> outputs zeroed, protocol_err=1, no valid.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the DDRAM burst arbiter: FSM states, default
// widths and the burst-length clamp used when latching a request.
package ddram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      HALTED
   } arb_state_e;

   localparam int ADDR_W_DEF    = 29;
   localparam int MAX_BURST_DEF = 128;
   localparam int BURST_CLAMP   = MAX_BURST_DEF;

   // A zero-length request still costs one beat; oversize requests are cut to the limit.
   function automatic logic [7:0] clamp_burst(input logic [7:0] cnt, input logic [7:0] max_cnt);
      if (cnt == 8'd0) begin
         return 8'd1;
      end
      if (cnt > max_cnt) begin
         return max_cnt;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ddram_burst_arbiter_if.sv
// Bundle of the two requester ports plus the DDRAM command/response side.
// The slave modport is the arbiter's view; master is the environment's view.
interface ddram_burst_arbiter_if
   import ddram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              req0_rd;
   logic              req1_rd;
   logic [ADDR_W-1:0] req0_addr;
   logic [ADDR_W-1:0] req1_addr;
   logic [7:0]        req0_burstcnt;
   logic [7:0]        req1_burstcnt;
   logic              req0_ack;
   logic              req1_ack;
   logic [63:0]       rd_data;
   logic              req0_valid;
   logic              req1_valid;
   logic              halt;
   logic              halted;
   logic              protocol_err;
   logic              ddram_busy;
   logic [63:0]       ddram_dout;
   logic              ddram_dout_ready;
   logic              ddram_rd;
   logic [ADDR_W-1:0] ddram_addr;
   logic [7:0]        ddram_burstcnt;

   modport slave (
      input  req0_rd, req1_rd, req0_addr, req1_addr, req0_burstcnt, req1_burstcnt,
      input  halt, ddram_busy, ddram_dout, ddram_dout_ready,
      output req0_ack, req1_ack, rd_data, req0_valid, req1_valid,
      output halted, protocol_err, ddram_rd, ddram_addr, ddram_burstcnt
   );

   modport master (
      output req0_rd, req1_rd, req0_addr, req1_addr, req0_burstcnt, req1_burstcnt,
      output halt, ddram_busy, ddram_dout, ddram_dout_ready,
      input  req0_ack, req1_ack, rd_data, req0_valid, req1_valid,
      input  halted, protocol_err, ddram_rd, ddram_addr, ddram_burstcnt
   );

endinterface

// File: rtl/ddram_burst_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. The requester served last loses a tie; the
// history only moves when the owner's burst has fully completed.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic       grant_valid,
   output logic       grant
);

   logic last_q;
   logic last_d;

   always_comb begin
      last_d = last_q;
      if (update) begin
         last_d = served;
      end
   end

   // Reset value 1 makes requester 0 the tie winner out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      grant_valid = |req;
      grant       = 1'b0;
      if (req == 2'b11) begin
         grant = ~last_q;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/ddram_burst_arbiter.sv
// Shares one DDRAM read port between two burst requesters: grants one command,
// waits out DDRAM back-pressure, then steers every returned beat to its owner.
module ddram_burst_arbiter
   import ddram_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_BURST = BURST_CLAMP
) (
   input logic                  clk,
   input logic                  reset,
   ddram_burst_arbiter_if.slave bus
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        burstcnt_q, burstcnt_d;
   logic [7:0]        beat_q, beat_d;
   logic [63:0]       rd_data_q, rd_data_d;
   logic [1:0]        valid_q, valid_d;
   logic              err_q, err_d;

   logic arb_valid;
   logic arb_grant;
   logic arb_update;

   rr_arbiter2 u_rr (
      .clk         (clk),
      .reset       (reset),
      .req         ({bus.req1_rd, bus.req0_rd}),
      .update      (arb_update),
      .served      (grant_q),
      .grant_valid (arb_valid),
      .grant       (arb_grant)
   );

   // Address and length are only written on a grant, so they stay put through the whole burst.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      burstcnt_d   = burstcnt_q;
      beat_d       = beat_q;
      rd_data_d    = rd_data_q;
      valid_d      = 2'b00;
      err_d        = err_q;
      arb_update   = 1'b0;
      bus.ddram_rd = 1'b0;
      bus.req0_ack = 1'b0;
      bus.req1_ack = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.halt) begin
               state_d = HALTED;
            end else if (arb_valid) begin
               grant_d    = arb_grant;
               addr_d     = arb_grant ? bus.req1_addr : bus.req0_addr;
               burstcnt_d = clamp_burst(arb_grant ? bus.req1_burstcnt : bus.req0_burstcnt, MAX_CNT);
               state_d    = CMD;
            end
         end
         CMD: begin
            bus.ddram_rd = 1'b1;
            if (!bus.ddram_busy) begin
               bus.req0_ack = ~grant_q;
               bus.req1_ack = grant_q;
               beat_d       = 8'd0;
               state_d      = DATA;
            end
         end
         DATA: begin
            if (bus.ddram_dout_ready) begin
               rd_data_d = bus.ddram_dout;
               if (grant_q) begin
                  valid_d[1] = 1'b1;
               end else begin
                  valid_d[0] = 1'b1;
               end
               if (beat_q == burstcnt_q - 8'd1) begin
                  arb_update = 1'b1;
                  state_d    = bus.halt ? HALTED : IDLE;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         HALTED: begin
            if (!bus.halt) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.ddram_dout_ready && (state_q != DATA)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         addr_q     <= '0;
         burstcnt_q <= 8'd0;
         beat_q     <= 8'd0;
         rd_data_q  <= 64'd0;
         valid_q    <= 2'b00;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         burstcnt_q <= burstcnt_d;
         beat_q     <= beat_d;
         rd_data_q  <= rd_data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign bus.ddram_addr     = addr_q;
   assign bus.ddram_burstcnt = burstcnt_q;
   assign bus.rd_data        = rd_data_q;
   assign bus.req0_valid     = valid_q[0];
   assign bus.req1_valid     = valid_q[1];
   assign bus.halted         = (state_q == HALTED);
   assign bus.protocol_err   = err_q;

endmodule

// File: tb/tb_ddram_burst_arbiter.sv
// Bench for ddram_burst_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_ddram_burst_arbiter;

   localparam int AW   = 29;
   localparam int MAXB = 128;

   logic clk;
   logic reset;

   ddram_burst_arbiter_if #(.ADDR_W(AW)) bus ();

   ddram_burst_arbiter #(.ADDR_W(AW), .MAX_BURST(MAXB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks_done    = 0;
   int check_failures = 0;

   logic          d_reset, d_halt, d_busy, d_rdy, pend0, pend1, auto_rdy;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [7:0]    p0_len, p1_len;
   int            rdy_pct;

   logic          a_reset, a_req0, a_req1, a_halt, a_busy, a_rdy;
   logic [AW-1:0] a_addr0, a_addr1;
   logic [7:0]    a_len0, a_len1;
   logic [63:0]   a_dout;

   // Reference model: one burst record (owner, length, beats still owed) plus sticky flags.
   bit            m_burst, m_cmd_done, m_valid0, m_valid1, m_err, m_halted;
   int            m_left, m_owner, m_last, m_len;
   logic [AW-1:0] m_addr;
   logic [63:0]   m_data;
   bit            exp_ack0, exp_ack1;

   int cnt_rd, cnt_v0, cnt_v1, grant_n;
   logic [7:0] obs_bc;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks_done++;
      if (observed !== expected) begin
         check_failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int clampLen(input int n);
      if (n == 0) return 1;
      if (n > MAXB) return MAXB;
      return n;
   endfunction

   function automatic logic [7:0] randLen();
      if ($urandom_range(99) < 8) return 8'($urandom_range(120, 255));
      return 8'($urandom_range(0, 9));
   endfunction

   task automatic modelStep();
      if (a_reset) begin
         m_burst = 0; m_cmd_done = 0; m_left = 0; m_owner = 0; m_last = 1;
         m_addr = '0; m_len = 0; m_valid0 = 0; m_valid1 = 0; m_data = 64'd0;
         m_err = 0; m_halted = 0;
         return;
      end
      m_valid0 = 0;
      m_valid1 = 0;
      if (a_rdy && !(m_burst && m_cmd_done)) m_err = 1;
      if (m_burst && m_cmd_done) begin
         if (a_rdy) begin
            m_data = a_dout;
            if (m_owner == 0) m_valid0 = 1; else m_valid1 = 1;
            m_left--;
            if (m_left == 0) begin
               m_burst  = 0;
               m_last   = m_owner;
               m_halted = a_halt;
            end
         end
      end else if (m_burst) begin
         if (!a_busy) begin
            m_cmd_done = 1;
            m_left     = m_len;
         end
      end else if (m_halted) begin
         if (!a_halt) m_halted = 0;
      end else if (a_halt) begin
         m_halted = 1;
      end else if (a_req0 || a_req1) begin
         if (a_req0 && a_req1) m_owner = 1 - m_last;
         else m_owner = a_req1 ? 1 : 0;
         m_burst    = 1;
         m_cmd_done = 0;
         m_addr     = (m_owner == 1) ? a_addr1 : a_addr0;
         m_len      = clampLen(int'((m_owner == 1) ? a_len1 : a_len0));
      end
   endtask

   task automatic checkAll();
      bit exp_rd;
      exp_rd   = m_burst && !m_cmd_done;
      exp_ack0 = exp_rd && !a_busy && (m_owner == 0);
      exp_ack1 = exp_rd && !a_busy && (m_owner == 1);
      checkOutput("ddram_rd", 64'(bus.ddram_rd), 64'(exp_rd));
      checkOutput("ddram_addr", 64'(bus.ddram_addr), 64'(m_addr));
      checkOutput("ddram_burstcnt", 64'(bus.ddram_burstcnt), 64'(m_len));
      checkOutput("req0_ack", 64'(bus.req0_ack), 64'(exp_ack0));
      checkOutput("req1_ack", 64'(bus.req1_ack), 64'(exp_ack1));
      checkOutput("req0_valid", 64'(bus.req0_valid), 64'(m_valid0));
      checkOutput("req1_valid", 64'(bus.req1_valid), 64'(m_valid1));
      checkOutput("rd_data", bus.rd_data, m_data);
      checkOutput("halted", 64'(bus.halted), 64'(m_halted));
      checkOutput("protocol_err", 64'(bus.protocol_err), 64'(m_err));
      if (exp_ack0) pend0 = 1'b0;
      if (exp_ack1) pend1 = 1'b0;
   endtask

   // One clock: model takes the edge, new inputs go on 1ns later, outputs are judged at negedge.
   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
      if (auto_rdy) d_rdy = (m_burst && m_cmd_done) && ($urandom_range(99) < rdy_pct);
      a_reset = d_reset; a_req0 = pend0; a_req1 = pend1;
      a_addr0 = p0_addr; a_addr1 = p1_addr; a_len0 = p0_len; a_len1 = p1_len;
      a_halt = d_halt; a_busy = d_busy; a_rdy = d_rdy;
      a_dout = {$urandom(), $urandom()};
      reset = a_reset;
      bus.req0_rd = a_req0; bus.req1_rd = a_req1;
      bus.req0_addr = a_addr0; bus.req1_addr = a_addr1;
      bus.req0_burstcnt = a_len0; bus.req1_burstcnt = a_len1;
      bus.halt = a_halt; bus.ddram_busy = a_busy;
      bus.ddram_dout_ready = a_rdy; bus.ddram_dout = a_dout;
      @(negedge clk);
      checkAll();
   endtask

   task automatic doReset();
      pend0 = 0; pend1 = 0; d_halt = 0; d_busy = 0;
      d_reset = 1;
      applyStimulus();
      applyStimulus();
      d_reset = 0;
   endtask

   initial begin
      d_reset = 1; d_halt = 0; d_busy = 0; d_rdy = 0; pend0 = 0; pend1 = 0;
      auto_rdy = 1; rdy_pct = 100;
      p0_addr = '0; p1_addr = '0; p0_len = 8'd0; p1_len = 8'd0;
      a_reset = 1; a_req0 = 0; a_req1 = 0; a_halt = 0; a_busy = 0; a_rdy = 0;
      a_addr0 = '0; a_addr1 = '0; a_len0 = 8'd0; a_len1 = 8'd0; a_dout = 64'd0;
      reset = 1;
      bus.req0_rd = 0; bus.req1_rd = 0; bus.req0_addr = '0; bus.req1_addr = '0;
      bus.req0_burstcnt = 8'd0; bus.req1_burstcnt = 8'd0; bus.halt = 0;
      bus.ddram_busy = 0; bus.ddram_dout = 64'd0; bus.ddram_dout_ready = 0;

      doReset();
      checkOutput("reset_ddram_rd", 64'(bus.ddram_rd), 64'd0);
      checkOutput("reset_rd_data", bus.rd_data, 64'd0);

      // Single 4-beat read by requester 0.
      pend0 = 1; p0_addr = AW'(32'h0240_0000); p0_len = 8'd4;
      cnt_rd = 0; cnt_v0 = 0; obs_bc = 8'd0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         applyStimulus();
         if (bus.ddram_rd) begin cnt_rd++; obs_bc = bus.ddram_burstcnt; end
         if (bus.req0_valid) cnt_v0++;
      end
      checkOutput("s1_rd_cycles", 64'(cnt_rd), 64'd1);
      checkOutput("s1_burstcnt", 64'(obs_bc), 64'd4);
      checkOutput("s1_beats0", 64'(cnt_v0), 64'd4);

      // Both requesting continuously, grants must alternate starting with 0.
      doReset();
      pend0 = 1; pend1 = 1; p0_addr = AW'(32'h100); p1_addr = AW'(32'h200);
      p0_len = 8'd2; p1_len = 8'd2; grant_n = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         applyStimulus();
         if (bus.req0_ack || bus.req1_ack) begin
            if (grant_n < 6) checkOutput("s2_grant_order", 64'(bus.req1_ack), 64'(grant_n % 2));
            grant_n++;
         end
         if (cyc < 40) begin pend0 = 1; pend1 = 1; end
      end
      checkOutput("s2_enough_grants", 64'(grant_n >= 6), 64'd1);

      // DDRAM busy for 5 command cycles.
      pend0 = 1; p0_addr = AW'(32'h0ABC_DEF0); p0_len = 8'd3; cnt_rd = 0;
      d_busy = 0;
      applyStimulus();
      d_busy = 1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         applyStimulus();
         if (bus.ddram_rd) cnt_rd++;
         checkOutput("s3_addr_held", 64'(bus.ddram_addr), 64'(AW'(32'h0ABC_DEF0)));
         checkOutput("s3_no_early_ack", 64'(bus.req0_ack), 64'd0);
      end
      d_busy = 0;
      applyStimulus();
      checkOutput("s3_busy_rd_cycles", 64'(cnt_rd), 64'd5);
      checkOutput("s3_ack_sixth", 64'(bus.req0_ack), 64'd1);
      repeat (8) applyStimulus();

      // Length clamping: 0 becomes 1, 200 becomes MAX_BURST.
      pend0 = 1; p0_len = 8'd0; obs_bc = 8'hFF;
      for (int cyc = 0; cyc < 6; cyc++) begin
         applyStimulus();
         if (bus.ddram_rd) obs_bc = bus.ddram_burstcnt;
      end
      checkOutput("s5_len0", 64'(obs_bc), 64'd1);
      pend1 = 1; p1_len = 8'd200; obs_bc = 8'h00; cnt_v1 = 0;
      for (int cyc = 0; cyc < 140; cyc++) begin
         applyStimulus();
         if (bus.ddram_rd) obs_bc = bus.ddram_burstcnt;
         if (bus.req1_valid) cnt_v1++;
      end
      checkOutput("s5_len200", 64'(obs_bc), 64'd128);
      checkOutput("s5_beats200", 64'(cnt_v1), 64'd128);

      // Halt raised mid-burst: burst completes, then park with req1 still waiting.
      pend0 = 1; p0_addr = AW'(32'h0100_0000); p0_len = 8'd128;
      pend1 = 1; p1_addr = AW'(32'h0000_0040); p1_len = 8'd2;
      cnt_v0 = 0; cnt_rd = 0;
      for (int cyc = 0; cyc < 150; cyc++) begin
         applyStimulus();
         if (bus.req0_valid) cnt_v0++;
         if (d_halt && bus.ddram_rd) cnt_rd++;
         if (cnt_v0 == 3) d_halt = 1;
      end
      checkOutput("s4_beats", 64'(cnt_v0), 64'd128);
      checkOutput("s4_no_rd_halted", 64'(cnt_rd), 64'd0);
      checkOutput("s4_halted", 64'(bus.halted), 64'd1);
      d_halt = 0;
      applyStimulus();
      applyStimulus();
      checkOutput("s4_unhalted", 64'(bus.halted), 64'd0);
      repeat (10) applyStimulus();

      // Reset at beat 10 while DDRAM keeps returning data.
      pend0 = 1; p0_addr = AW'(32'h0033_0000); p0_len = 8'd128; cnt_v0 = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         applyStimulus();
         if (bus.req0_valid) cnt_v0++;
         if (cnt_v0 == 10) break;
      end
      checkOutput("s6_reached_beat10", 64'(cnt_v0), 64'd10);
      d_reset = 1;
      applyStimulus();
      d_reset = 0; auto_rdy = 0; d_rdy = 1; cnt_v0 = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         applyStimulus();
         if (bus.req0_valid || bus.req1_valid) cnt_v0++;
      end
      checkOutput("s6_no_valid", 64'(cnt_v0), 64'd0);
      checkOutput("s6_protocol_err", 64'(bus.protocol_err), 64'd1);
      checkOutput("s6_addr_zero", 64'(bus.ddram_addr), 64'd0);
      checkOutput("s6_burstcnt_zero", 64'(bus.ddram_burstcnt), 64'd0);
      d_rdy = 0; auto_rdy = 1;
      doReset();

      // Random traffic with back-pressure, halts and requesters dropping after grant.
      rdy_pct = 60;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         d_busy = ($urandom_range(99) < 30);
         if ($urandom_range(99) < 4) d_halt = ~d_halt;
         if (!pend0 && !(m_burst && m_owner == 0) && $urandom_range(99) < 25) begin
            pend0 = 1; p0_addr = AW'($urandom()); p0_len = randLen();
         end
         if (!pend1 && !(m_burst && m_owner == 1) && $urandom_range(99) < 25) begin
            pend1 = 1; p1_addr = AW'($urandom()); p1_len = randLen();
         end
         if (pend0 && m_burst && m_owner == 0 && !m_cmd_done && $urandom_range(99) < 10) pend0 = 0;
         if (pend1 && m_burst && m_owner == 1 && !m_cmd_done && $urandom_range(99) < 10) pend1 = 0;
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks_done, check_failures);
      $finish;
   end

endmodule
